// File: rtl/oc15_popcount_sequencer.sv
// oc15_popcount_sequencer
// Counts the ones in a wide word by feeding it, one 15-bit slice per clock, through a
// single 15-input ones-counter. It accumulates the slice counts, then reports the total
// and a majority flag, and raises a one-cycle done pulse.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous reset, active-high
//   start    - request to count data_in; sampled only when not busy
//   data_in  - word to count (15*SLICES bits); bits [14:0] are slice 0
//   busy     - high while a word is being counted
//   done     - one-cycle pulse when count/majority are updated
//   count    - total number of ones in the last completed word
//   majority - high when 2*count > 15*SLICES for the last completed word
module oc15_popcount_sequencer #(
  parameter int unsigned SLICES = 4,
  // 2**SUM_W must exceed 15*SLICES
  parameter int unsigned SUM_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15*SLICES-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [SUM_W-1:0]     count,
  output logic                 majority
);

  localparam int unsigned Width = 15 * SLICES;
  localparam int unsigned IdxW  = (SLICES > 1) ? $clog2(SLICES) : 1;
  // Majority compares 2*sum against Width; one extra bit holds the doubled sum.
  localparam logic [SUM_W:0]   MajThresh = (SUM_W + 1)'(Width);
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(SLICES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [Width-1:0]   shreg_q, shreg_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [SUM_W-1:0]   count_q, count_d;
  logic               majority_q, majority_d;

  logic [3:0]         slice_ones;
  logic [SUM_W-1:0]   sum_next;
  logic               idx_last;
  logic               accept;

  // The single shared 15-input ones-counter, always looking at the low slice.
  always_comb begin
    slice_ones = 4'd0;
    for (int i = 0; i < 15; i++) begin
      slice_ones = slice_ones + {3'b000, shreg_q[i]};
    end
  end

  assign sum_next = acc_q + SUM_W'(slice_ones);
  assign idx_last = (idx_q == LastIdx);

  // A new word can be taken in IDLE and also in DONE, which avoids an idle gap between
  // back-to-back words.
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    count_d    = count_q;
    majority_d = majority_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCount;
        end
      end
      StCount: begin
        acc_d   = sum_next;
        shreg_d = shreg_q >> 15;
        idx_d   = idx_q + 1'b1;
        if (idx_last) begin
          count_d    = sum_next;
          majority_d = ({sum_next, 1'b0} > MajThresh);
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = start ? StCount : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      shreg_d = data_in;
      acc_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      majority_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      majority_q <= majority_d;
    end
  end

  // Status outputs decode the state register only; start never reaches them directly.
  assign busy     = (state_q == StCount);
  assign done     = (state_q == StDone);
  assign count    = count_q;
  assign majority = majority_q;

endmodule

// File: tb/tb_oc15_popcount_sequencer.sv
module tb_oc15_popcount_sequencer;

  localparam int unsigned SLICES = 4;
  localparam int unsigned SUM_W  = 6;
  localparam int unsigned W      = 15 * SLICES;

  logic             clk;
  logic             rst;
  logic             start;
  logic [W-1:0]     data_in;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] count;
  logic             majority;

  int n_cmp;
  int n_err;

  oc15_popcount_sequencer #(
    .SLICES(SLICES),
    .SUM_W (SUM_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .majority(majority)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: total number of set bits, and majority of the whole word.
  function automatic int unsigned ref_count(input logic [W-1:0] w);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(W); i++) c += w[i];
    return c;
  endfunction

  function automatic logic ref_maj(input logic [W-1:0] w);
    return (2 * ref_count(w)) > W;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [63:0] a, b;
    int unsigned mode;
    a    = {$urandom, $urandom};
    b    = {$urandom, $urandom};
    mode = $urandom_range(0, 3);
    case (mode)
      0: return a[W-1:0];
      1: return a[W-1:0] & b[W-1:0];
      2: return a[W-1:0] | b[W-1:0];
      default: return (a[0]) ? '1 : '0;
    endcase
  endfunction

  // Drive a one-cycle start; returns at the falling edge after the accepting edge.
  task automatic pulse_start(input logic [W-1:0] w);
    @(negedge clk);
    start   = 1'b1;
    data_in = w;
    @(negedge clk);
    start   = 1'b0;
    data_in = '0;
  endtask

  // Wait (bounded) for done; cycles counts falling edges waited.
  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < 20) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    // Reset asserted before the first rising edge
    rst = 1'b1;
    start = 1'b0;
    data_in = '0;
    #1;
    n_cmp++;
    if ({busy, done, count, majority} !== '0) begin
      n_err++;
      $display("FAIL reset_async: busy=%b done=%b count=%0d maj=%b, required all 0",
               busy, done, count, majority);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, count, majority} !== '0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: busy=%b done=%b count=%0d maj=%b, required all 0",
                 i, busy, done, count, majority);
      end
    end
  endtask

  task automatic test_zero();
    pulse_start('0);
    for (int i = 0; i < int'(SLICES); i++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL zero_busy[%0d]: busy=%b done=%b, required busy=1 done=0", i, busy, done);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 6'd0 || majority !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: done=%b busy=%b count=%0d maj=%b, required 1 0 0 0",
               done, busy, count, majority);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_after: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_ones();
    int cyc;
    bit ok;
    pulse_start('1);
    wait_done(cyc, ok);
    n_cmp++;
    if (!ok || count !== 6'd60 || majority !== 1'b1) begin
      n_err++;
      $display("FAIL ones: done_seen=%0d count=%0d maj=%b, required done count=60 maj=1",
               ok, count, majority);
    end
  endtask

  task automatic test_mixed();
    logic [W-1:0] w;
    int cyc;
    bit ok;
    w = {15'h0001, 15'h0003, 15'h0007, 15'h000F};
    pulse_start(w);
    wait_done(cyc, ok);
    n_cmp++;
    if (!ok || count !== 6'd10 || majority !== 1'b0) begin
      n_err++;
      $display("FAIL mixed_a: done_seen=%0d count=%0d maj=%b, required count=10 maj=0",
               ok, count, majority);
    end
    w = {15'h0000, 15'h00FF, 15'h7FFF, 15'h7FFF};
    pulse_start(w);
    wait_done(cyc, ok);
    n_cmp++;
    if (!ok || count !== 6'd38 || majority !== 1'b1) begin
      n_err++;
      $display("FAIL mixed_b: done_seen=%0d count=%0d maj=%b, required count=38 maj=1",
               ok, count, majority);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    logic [SUM_W-1:0] prev;
    int cyc;
    bit ok;
    prev = count;
    for (int n = 0; n < 25; n++) begin
      w = rand_word();
      pulse_start(w);
      // Previous result must hold during the new COUNT phase
      n_cmp++;
      if (count !== prev) begin
        n_err++;
        $display("FAIL rand_hold[%0d]: count=%0d, required %0d", n, count, prev);
      end
      wait_done(cyc, ok);
      n_cmp++;
      if (!ok || cyc != int'(SLICES) || count !== SUM_W'(ref_count(w)) ||
          majority !== ref_maj(w)) begin
        n_err++;
        $display("FAIL rand[%0d]: w=%h ok=%0d lat=%0d count=%0d maj=%b, required lat=%0d count=%0d maj=%b",
                 n, w, ok, cyc, count, majority, SLICES, ref_count(w), ref_maj(w));
      end
      prev = SUM_W'(ref_count(w));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a, b;
    int cyc;
    bit ok;
    a = {15'h0001, 15'h0003, 15'h0007, 15'h000F};
    b = '1;
    pulse_start(a);
    @(negedge clk);
    start   = 1'b1;
    data_in = b;
    @(negedge clk);
    start   = 1'b0;
    data_in = '0;
    wait_done(cyc, ok);
    n_cmp++;
    if (!ok || count !== SUM_W'(ref_count(a)) || majority !== ref_maj(a)) begin
      n_err++;
      $display("FAIL ignore_start: ok=%0d count=%0d maj=%b, required count=%0d maj=%b",
               ok, count, majority, ref_count(a), ref_maj(a));
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_not_queued: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    int cyc;
    bit ok;
    a = rand_word();
    b = ~a;
    pulse_start(a);
    wait_done(cyc, ok);
    n_cmp++;
    if (!ok || count !== SUM_W'(ref_count(a))) begin
      n_err++;
      $display("FAIL b2b_first: ok=%0d count=%0d, required %0d", ok, count, ref_count(a));
    end
    // Start held through the DONE cycle
    start   = 1'b1;
    data_in = b;
    @(negedge clk);
    start   = 1'b0;
    data_in = '0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_no_gap: busy=%b, required 1", busy);
    end
    wait_done(cyc, ok);
    n_cmp++;
    if (!ok || cyc + 1 != int'(SLICES) + 1 || count !== SUM_W'(ref_count(b)) ||
        majority !== ref_maj(b)) begin
      n_err++;
      $display("FAIL b2b_second: ok=%0d spacing=%0d count=%0d maj=%b, required 5 %0d %b",
               ok, cyc + 1, count, majority, ref_count(b), ref_maj(b));
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    int cyc;
    bit ok;
    bit seen;
    w = {15'h0001, 15'h0003, 15'h0007, 15'h000F};
    pulse_start(w);
    wait_done(cyc, ok);
    pulse_start('1);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || count !== 6'd10) begin
      n_err++;
      $display("FAIL mid_pre: busy=%b count=%0d, required busy=1 count=10", busy, count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, count, majority} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b done=%b count=%0d maj=%b, required all 0",
               busy, done, count, majority);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL mid_no_done: activity after aborted word=%0d, required 0", seen);
    end
    w = rand_word();
    pulse_start(w);
    wait_done(cyc, ok);
    n_cmp++;
    if (!ok || count !== SUM_W'(ref_count(w)) || majority !== ref_maj(w)) begin
      n_err++;
      $display("FAIL mid_recover: ok=%0d count=%0d maj=%b, required count=%0d maj=%b",
               ok, count, majority, ref_count(w), ref_maj(w));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_zero();
    test_ones();
    test_mixed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
